// File: rtl/lut_func_pkg.sv
// rtl/lut_func_pkg.sv - shared constants, config FSM states and sizing helpers for lut_func_unit
package lut_func_pkg;
    localparam int HIT_CNT_W = 16;
    localparam logic [63:0] LUT_DEFAULT_TT = 64'h0000_0000_0000_F830;

    typedef logic [1:0] cfg_state_t;
    localparam cfg_state_t CFG_IDLE   = 2'd0;
    localparam cfg_state_t CFG_LOAD   = 2'd1;
    localparam cfg_state_t CFG_COMMIT = 2'd2;

    function automatic int tt_w(input int n_in);
        return 1 << n_in;
    endfunction

    // A single-channel build still carries a 1-bit channel select.
    function automatic int ch_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction
endpackage

// File: rtl/lut_cfg_loader.sv
// rtl/lut_cfg_loader.sv - serial truth-table loader: IDLE/LOAD/COMMIT FSM, bit counter, shadow register
module lut_cfg_loader
    import lut_func_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int CH   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_start,
    input  logic [ch_w(CH)-1:0]     cfg_ch,
    input  logic                    cfg_bit,
    output logic                    cfg_busy,
    output logic                    commit,
    output logic [ch_w(CH)-1:0]     commit_ch,
    output logic [tt_w(N_IN)-1:0]   commit_tt
);
    localparam int TT_W = tt_w(N_IN);
    localparam int CHW  = ch_w(CH);

    cfg_state_t       state;
    logic [N_IN-1:0]  cnt;
    logic [CHW-1:0]   ch_q;
    logic [TT_W-1:0]  shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CFG_IDLE;
            cnt    <= '0;
            ch_q   <= '0;
            shadow <= '0;
        end else begin
            case (state)
                CFG_IDLE: begin
                    if (cfg_start) begin
                        state <= CFG_LOAD;
                        ch_q  <= cfg_ch;
                        cnt   <= '0;
                    end
                end
                CFG_LOAD: begin
                    shadow[cnt] <= cfg_bit;
                    cnt         <= cnt + 1'b1;
                    if (cnt == N_IN'(TT_W - 1)) begin
                        state <= CFG_COMMIT;
                    end
                end
                CFG_COMMIT: state <= CFG_IDLE;
                default:    state <= CFG_IDLE;
            endcase
        end
    end

    // An out-of-range channel still runs the full load; only the write is dropped.
    assign cfg_busy  = (state != CFG_IDLE);
    assign commit    = (state == CFG_COMMIT) && ({1'b0, ch_q} < (CHW + 1)'(CH));
    assign commit_ch = ch_q;
    assign commit_tt = shadow;
endmodule

// File: rtl/lut_func_unit.sv
// rtl/lut_func_unit.sv - multi-channel LUT boolean function unit, 2-stage pipeline; optional LUT_FUNC_HIT_CNT_EN
module lut_func_unit
    import lut_func_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int CH   = 2,
    parameter logic [tt_w(N_IN)-1:0] DEFAULT_TT = LUT_DEFAULT_TT[tt_w(N_IN)-1:0]
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH*N_IN-1:0]    in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH-1:0]         out_data,
    input  logic                  cfg_start,
    input  logic [ch_w(CH)-1:0]   cfg_ch,
    input  logic                  cfg_bit,
    output logic                  cfg_busy
`ifdef LUT_FUNC_HIT_CNT_EN
    , output logic [CH*HIT_CNT_W-1:0] hit_cnt
`endif
);
    localparam int TT_W = tt_w(N_IN);
    localparam int CHW  = ch_w(CH);

    logic [TT_W-1:0]    tbl [CH];
    logic               s1_valid;
    logic [CH*N_IN-1:0] s1_data;
    logic               s2_advance;
    logic [CH-1:0]      lookup;
    logic               cfg_commit;
    logic [CHW-1:0]     cfg_commit_ch;
    logic [TT_W-1:0]    cfg_commit_tt;

    lut_cfg_loader #(.N_IN(N_IN), .CH(CH)) u_loader (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_ch    (cfg_ch),
        .cfg_bit   (cfg_bit),
        .cfg_busy  (cfg_busy),
        .commit    (cfg_commit),
        .commit_ch (cfg_commit_ch),
        .commit_tt (cfg_commit_tt)
    );

    assign s2_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s2_advance;

    always_comb begin
        lookup = '0;
        for (int c = 0; c < CH; c++) begin
            lookup[c] = tbl[c][s1_data[c*N_IN +: N_IN]];
        end
    end

    // Table write lands at the end of the COMMIT cycle, so S2 captures with the old table until then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                tbl[c] <= DEFAULT_TT;
            end
        end else if (cfg_commit) begin
            tbl[cfg_commit_ch] <= cfg_commit_tt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_data <= in_data;
                end
            end
            if (s2_advance) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= lookup;
                end
            end
        end
    end

`ifdef LUT_FUNC_HIT_CNT_EN
    logic [HIT_CNT_W-1:0] hits [CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                hits[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (cfg_commit && cfg_commit_ch == CHW'(c)) begin
                    hits[c] <= '0;
                end else if (out_valid && out_ready && out_data[c] && hits[c] != '1) begin
                    hits[c] <= hits[c] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        hit_cnt = '0;
        for (int c = 0; c < CH; c++) begin
            hit_cnt[c*HIT_CNT_W +: HIT_CNT_W] = hits[c];
        end
    end
`endif
endmodule

// File: tb/tb_lut_func_unit.sv
// tb/tb_lut_func_unit.sv - self-checking bench for lut_func_unit; LUT_FUNC_HIT_CNT_EN adds the counter test
module tb_lut_func_unit;
    localparam int N_IN = 4;
    localparam int CH   = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [CH*N_IN-1:0] in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [CH-1:0]   out_data;
    logic            cfg_start = 1'b0;
    logic            cfg_ch = 1'b0;
    logic            cfg_bit = 1'b0;
    logic            cfg_busy;
`ifdef LUT_FUNC_HIT_CNT_EN
    logic [CH*16-1:0] hit_cnt;
`endif

    lut_func_unit #(.N_IN(N_IN), .CH(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_start (cfg_start),
        .cfg_ch    (cfg_ch),
        .cfg_bit   (cfg_bit),
        .cfg_busy  (cfg_busy)
`ifdef LUT_FUNC_HIT_CNT_EN
        , .hit_cnt (hit_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    logic [15:0]   model_tt [CH];
    logic [CH-1:0] exp_q [$];
    logic          stall_prev = 1'b0;
    logic [CH-1:0] stall_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Result bit c is simply bit <operand c> of channel c's current truth table.
    function automatic logic [CH-1:0] model_eval(input logic [CH*N_IN-1:0] d);
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = model_tt[c][d[c*N_IN +: N_IN]];
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_result", exp_q.size(), 1);
                else check("scoreboard", out_data, exp_q.pop_front());
                n_out++;
            end
            if (out_valid && !out_ready) begin
                if (stall_prev) check("stall_hold", out_data, stall_data);
                stall_prev <= 1'b1;
                stall_data <= out_data;
            end else begin
                stall_prev <= 1'b0;
            end
            if (in_valid && in_ready) exp_q.push_back(model_eval(in_data));
        end
    end

    task automatic send_one(input logic [CH*N_IN-1:0] d, output logic [CH-1:0] r);
        int t;
        in_data = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!out_valid) check("send_timeout", out_valid, 1);
        r = out_data;
        @(posedge clk); #1;
    endtask

    task automatic load_tt(input logic ch, input logic [15:0] tt, input int stray_at, output int busy);
        busy = 0;
        cfg_ch = ch;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        busy += int'(cfg_busy);
        for (int i = 0; i < 16; i++) begin
            cfg_bit = tt[i];
            if (i == stray_at) begin
                cfg_start = 1'b1;
                cfg_ch = ~ch;
            end
            @(posedge clk); #1;
            cfg_start = 1'b0;
            cfg_ch = ch;
            busy += int'(cfg_busy);
        end
        @(posedge clk); #1;
        busy += int'(cfg_busy);
        model_tt[ch] = tt;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CH-1:0] r;
        int busy;
        int t;
        int out_base;
        for (int c = 0; c < CH; c++) model_tt[c] = 16'hF830;

        check("model_pin_default", model_eval({4'b1011, 4'b0011}), 2'b10);
        check("model_pin_op4", model_eval({4'b0100, 4'b0100}), 2'b11);

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_cfg_busy", cfg_busy, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        in_data = {4'b1011, 4'b0011};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat1_out_valid", out_valid, 0);
        @(posedge clk); #1;
        check("lat2_out_valid", out_valid, 1);
        check("lat2_out_data", out_data, 2'b10);
        @(posedge clk); #1;
        check("drained_out_valid", out_valid, 0);

        send_one({4'b0100, 4'b0100}, r);
        check("op4_both", r, 2'b11);
        send_one({4'b0000, 4'b0000}, r);
        check("op0_both", r, 2'b00);

        // Stray cfg_start mid-load targets ch1 and must be ignored.
        load_tt(1'b0, 16'h0001, 5, busy);
        check("cfg_busy_cycles", busy, 17);
        check("cfg_busy_after", cfg_busy, 0);
        send_one({4'b0100, 4'b0000}, r);
        check("ch0_new_op0", r, 2'b11);
        send_one({4'b0000, 4'b1111}, r);
        check("ch0_new_op15", r, 2'b00);
        send_one({4'b1111, 4'b0100}, r);
        check("ch1_unchanged", r, 2'b10);

        out_base = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    in_data = {4'(i + 3), 4'(i * 2)};
                    in_valid = 1'b1;
                    @(negedge clk);
                    t = 0;
                    while (!in_ready && t < 50) begin
                        @(negedge clk);
                        t++;
                    end
                    if (!in_ready) check("stream_in_ready_timeout", in_ready, 1);
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                check("stall_in_ready_low", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("stream_count", n_out - out_base, 8);
        check("stream_queue_empty", exp_q.size(), 0);

        // Park a result at the output, then reset in the middle of a load.
        out_ready = 1'b0;
        in_data = {4'b0100, 4'b0100};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        cfg_ch = 1'b0;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cfg_bit = 1'b1;
            @(posedge clk); #1;
        end
        check("midload_busy", cfg_busy, 1);
        check("midload_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_cfg_busy", cfg_busy, 0);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_in_ready", in_ready, 1);
        exp_q.delete();
        for (int c = 0; c < CH; c++) model_tt[c] = 16'hF830;
        out_ready = 1'b1;
        cfg_bit = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_one({4'b0000, 4'b0000}, r);
        check("rst_table_default_op0", r, 2'b00);
        send_one({4'b0000, 4'b0100}, r);
        check("rst_table_default_op4", r, 2'b01);

`ifdef LUT_FUNC_HIT_CNT_EN
        load_tt(1'b1, 16'hFFFF, -1, busy);
        check("hit_cnt_cleared", hit_cnt[31:16], 16'h0000);
        in_data = {4'b0000, 4'b0000};
        in_valid = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("hit_cnt_saturated", hit_cnt[31:16], 16'hFFFF);
        load_tt(1'b1, 16'hFFFF, -1, busy);
        check("hit_cnt_commit_clear", hit_cnt[31:16], 16'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
